// File: rtl/cycle_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cycle_timer_pkg
// Description : Shared definitions for the cycle timer: FSM state encoding,
//               register map addresses and CTRL/STATUS bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package cycle_timer_pkg;

    // FSM state encoding; the value is visible in STATUS[3:2]
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2
    } state_t;

    // Register map
    localparam logic [1:0] ADDR_COMPARE = 2'd0;
    localparam logic [1:0] ADDR_PERIOD  = 2'd1;
    localparam logic [1:0] ADDR_CTRL    = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    // CTRL bit positions (ACK is a write-only strobe and always reads 0)
    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_ACK      = 2;

    // STATUS bit positions
    localparam int STATUS_PENDING  = 0;
    localparam int STATUS_OVERRUN  = 1;
    localparam int STATUS_STATE_LO = 2;
    localparam int STATUS_STATE_HI = 3;
    localparam int STATUS_BITS     = 4;

    // Packs the live STATUS fields into their read-back layout
    function automatic logic [STATUS_BITS-1:0] status_bits(
        input logic   pending,
        input logic   overrun,
        input state_t st
    );
        logic [STATUS_BITS-1:0] v;
        v                                  = '0;
        v[STATUS_PENDING]                  = pending;
        v[STATUS_OVERRUN]                  = overrun;
        v[STATUS_STATE_HI:STATUS_STATE_LO] = st;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_regfile.sv
`default_nettype none
// ============================================================================
// Module      : timer_regfile
// Description : Register storage for the cycle timer (COMPARE, PERIOD, CTRL,
//               PENDING/OVERRUN flags) and the registered read mux.
//               W must be at least 4 so the STATUS fields fit.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_regfile
    import cycle_timer_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_we,
    input  logic [1:0]   i_addr,
    input  logic [W-1:0] i_wdata,
    input  logic         i_event,
    input  logic         i_reload,
    input  logic [W-1:0] i_reload_value,
    input  state_t       i_state,
    output logic [W-1:0] o_compare,
    output logic [W-1:0] o_period,
    output logic         o_en,
    output logic         o_periodic,
    output logic         o_pending,
    output logic [W-1:0] o_rdata
);

    logic [W-1:0] r_compare;
    logic [W-1:0] r_period;
    logic         r_en;
    logic         r_periodic;
    logic         r_pending;
    logic         r_overrun;
    logic [W-1:0] r_rdata;

    logic         w_wr_compare;
    logic         w_wr_period;
    logic         w_wr_ctrl;
    logic         w_ack;
    logic [W-1:0] w_rdata;

    assign w_wr_compare = i_we && (i_addr == ADDR_COMPARE);
    assign w_wr_period  = i_we && (i_addr == ADDR_PERIOD);
    assign w_wr_ctrl    = i_we && (i_addr == ADDR_CTRL);
    assign w_ack        = w_wr_ctrl && i_wdata[CTRL_ACK];

    // COMPARE: a bus write beats a periodic reload arriving in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_compare <= '0;
        end else if (w_wr_compare) begin
            r_compare <= i_wdata;
        end else if (i_reload) begin
            r_compare <= i_reload_value;
        end
    end

    // PERIOD: only consulted at the next reload, never moves COMPARE directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_period <= '0;
        end else if (w_wr_period) begin
            r_period <= i_wdata;
        end
    end

    // CTRL: only EN and PERIODIC are stored; other written bits are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en       <= 1'b0;
            r_periodic <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_en       <= i_wdata[CTRL_EN];
            r_periodic <= i_wdata[CTRL_PERIODIC];
        end
    end

    // PENDING/OVERRUN: a fresh event wins over ACK for PENDING, ACK wins for OVERRUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_event) begin
                r_pending <= 1'b1;
            end else if (w_ack) begin
                r_pending <= 1'b0;
            end

            if (w_ack) begin
                r_overrun <= 1'b0;
            end else if (i_event && r_pending) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Read mux: selects the current value of the addressed register
    always_comb begin
        w_rdata = '0;
        case (i_addr)
            ADDR_COMPARE: w_rdata = r_compare;
            ADDR_PERIOD:  w_rdata = r_period;
            ADDR_CTRL: begin
                w_rdata[CTRL_EN]       = r_en;
                w_rdata[CTRL_PERIODIC] = r_periodic;
            end
            ADDR_STATUS: begin
                w_rdata[STATUS_BITS-1:0] = status_bits(r_pending, r_overrun, i_state);
            end
            default: w_rdata = '0;
        endcase
    end

    // Read data register: one cycle of latency, independent of the write strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rdata;
        end
    end

    assign o_compare  = r_compare;
    assign o_period   = r_period;
    assign o_en       = r_en;
    assign o_periodic = r_periodic;
    assign o_pending  = r_pending;
    assign o_rdata    = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// ============================================================================
// Module      : cycle_timer
// Description : Compare/period timer driven by an external free-running cycle
//               count. One-shot or periodic events raise PENDING and irq;
//               repeated events while PENDING set the sticky OVERRUN flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cycle_timer
    import cycle_timer_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] count_in,
    input  logic         we,
    input  logic [1:0]   addr,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         irq
);

    state_t       r_state;
    state_t       w_state_next;
    logic         r_irq;

    logic [W-1:0] w_compare;
    logic [W-1:0] w_period;
    logic         w_en;
    logic         w_periodic;
    logic         w_pending;
    logic [W-1:0] w_rdata;

    logic         w_wr_compare;
    logic         w_wr_ctrl;
    logic         w_match;
    logic         w_event;
    logic         w_oneshot;
    logic         w_reload;
    logic [W-1:0] w_reload_value;

    assign w_wr_compare = we && (addr == ADDR_COMPARE);
    assign w_wr_ctrl    = we && (addr == ADDR_CTRL);

    // Equality-only match, so counter wrap needs no special treatment
    assign w_match   = (r_state == ST_ARMED) && (count_in == w_compare);
    // A COMPARE write in the match cycle cancels the event entirely
    assign w_event   = w_match && !w_wr_compare;
    // PERIODIC with a zero PERIOD behaves as one-shot
    assign w_oneshot = !w_periodic || (w_period == '0);
    assign w_reload  = w_event && !w_oneshot;
    // Natural W-bit addition gives the modulo 2^W wrap
    assign w_reload_value = w_compare + w_period;

    timer_regfile #(
        .W (W)
    ) u_regfile (
        .clk            (clk),
        .rst            (rst),
        .i_we           (we),
        .i_addr         (addr),
        .i_wdata        (wdata),
        .i_event        (w_event),
        .i_reload       (w_reload),
        .i_reload_value (w_reload_value),
        .i_state        (r_state),
        .o_compare      (w_compare),
        .o_period       (w_period),
        .o_en           (w_en),
        .o_periodic     (w_periodic),
        .o_pending      (w_pending),
        .o_rdata        (w_rdata)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a CTRL write with EN=0 overrides every other transition
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_ctrl && wdata[CTRL_EN]) begin
                    w_state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_event && w_oneshot) begin
                    w_state_next = ST_FIRED;
                end
            end
            ST_FIRED: begin
                if (w_wr_compare && w_en) begin
                    w_state_next = ST_ARMED;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (w_wr_ctrl && !wdata[CTRL_EN]) begin
            w_state_next = ST_IDLE;
        end
    end

    // Interrupt: PENDING gated by EN, one register stage behind PENDING
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_pending && w_en;
        end
    end

    assign rdata = w_rdata;
    assign irq   = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cycle_timer
// Description : Self-checking bench for cycle_timer. Stimulus queues expected
//               rdata/irq values tagged with the clock edge they belong to;
//               a monitor compares them just after that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cycle_timer;
    import cycle_timer_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] count_in;
    logic         we;
    logic [1:0]   addr;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    logic         irq;

    cycle_timer #(
        .W (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .count_in (count_in),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned  cyc;
        bit           is_irq;
        logic [W-1:0] want;
        string        name;
    } exp_t;

    exp_t         sb[$];
    int unsigned  cyc_cnt = 0;
    int           n_pass  = 0;
    int           n_total = 0;
    logic [W-1:0] cnt;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_total = n_total + 1;
        if (got === want) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    // Expectation for rdata after the clock edge ending the current cycle
    task automatic exp_rd(input string name, input logic [W-1:0] v);
        exp_t e;
        e.cyc = cyc_cnt + 1; e.is_irq = 1'b0; e.want = v; e.name = name;
        sb.push_back(e);
    endtask

    // Expectation for irq after the clock edge ending the current cycle
    task automatic exp_irq(input string name, input logic v);
        exp_t e;
        e.cyc = cyc_cnt + 1; e.is_irq = 1'b1; e.want = {{(W-1){1'b0}}, v}; e.name = name;
        sb.push_back(e);
    endtask

    // One bus cycle with count_in = cnt; returns on the following falling edge
    task automatic cycle(input logic w, input logic [1:0] a, input logic [W-1:0] d);
        we = w; addr = a; wdata = d; count_in = cnt;
        @(negedge clk);
        cnt = cnt + 1;
        we  = 1'b0;
    endtask

    // Monitor: pops every expectation belonging to this edge
    always @(posedge clk) begin
        exp_t e;
        cyc_cnt = cyc_cnt + 1;
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            e = sb.pop_front();
            if (e.cyc != cyc_cnt) begin
                n_total = n_total + 1;
                $display("FAIL %s: got no sample expected a sample at edge %0d", e.name, e.cyc);
            end else if (e.is_irq) begin
                chk(e.name, {{(W-1){1'b0}}, irq}, e.want);
            end else begin
                chk(e.name, rdata, e.want);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; we = 1'b0; addr = '0; wdata = '0; count_in = '0; cnt = '0;
        #1 rst = 1'b1;
        #1;
        chk("reset_rdata", rdata, '0);
        chk("reset_irq", {{(W-1){1'b0}}, irq}, '0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Reset values through the read port
        exp_rd("rst_status", 0); exp_irq("rst_irq", 1'b0); cycle(1'b0, ADDR_STATUS, 0);
        exp_rd("rst_compare", 0); cycle(1'b0, ADDR_COMPARE, 0);
        exp_rd("rst_ctrl", 0); cycle(1'b0, ADDR_CTRL, 0);

        // One-shot at 100
        cycle(1'b1, ADDR_COMPARE, 100);
        cycle(1'b1, ADDR_CTRL, 32'hFFFF_FFF9);
        exp_rd("ctrl_reserved_bits", 1); cycle(1'b0, ADDR_CTRL, 0);
        cnt = 95;
        for (int c = 95; c <= 105; c++) begin
            exp_rd($sformatf("oneshot_status@%0d", c), (c <= 100) ? 32'd4 : 32'd9);
            exp_irq($sformatf("oneshot_irq@%0d", c), (c > 100));
            cycle(1'b0, ADDR_STATUS, 0);
        end
        exp_irq("oneshot_irq_at_ack", 1'b1); cycle(1'b1, ADDR_CTRL, 5);
        exp_rd("oneshot_status_acked", 8); exp_irq("oneshot_irq_dropped", 1'b0);
        cycle(1'b0, ADDR_STATUS, 0);
        cycle(1'b1, ADDR_CTRL, 0);

        // Periodic across the counter wrap
        cycle(1'b1, ADDR_COMPARE, 32'hFFFF_FFF0);
        exp_rd("period_rd_during_write", 0); cycle(1'b1, ADDR_PERIOD, 32'h20);
        exp_rd("period_rd_after_write", 32'h20); cycle(1'b0, ADDR_PERIOD, 0);
        cycle(1'b1, ADDR_CTRL, 3);
        cnt = 32'hFFFF_FFEE;
        while (cnt != 32'h12) begin
            if (cnt == 32'hFFFF_FFF0) begin
                exp_rd("wrap_compare_at_match", 32'hFFFF_FFF0); cycle(1'b0, ADDR_COMPARE, 0);
            end else if (cnt == 32'hFFFF_FFF1) begin
                exp_rd("wrap_status_first", 5); cycle(1'b0, ADDR_STATUS, 0);
            end else if (cnt == 32'hFFFF_FFF2) begin
                cycle(1'b1, ADDR_CTRL, 7);
            end else if (cnt == 32'h5) begin
                exp_rd("wrap_status_between", 4); cycle(1'b0, ADDR_STATUS, 0);
            end else if (cnt == 32'h11) begin
                exp_rd("wrap_compare_reloaded", 32'h30); cycle(1'b0, ADDR_COMPARE, 0);
            end else begin
                cycle(1'b0, ADDR_STATUS, 0);
            end
        end
        exp_rd("wrap_status_second", 5); cycle(1'b0, ADDR_STATUS, 0);
        cycle(1'b1, ADDR_CTRL, 4);

        // Overrun with PERIOD=4, then ACK
        cycle(1'b1, ADDR_COMPARE, 200);
        cycle(1'b1, ADDR_PERIOD, 4);
        cycle(1'b1, ADDR_CTRL, 3);
        cnt = 198;
        while (cnt <= 207) begin
            if (cnt == 203) begin
                exp_rd("ovr_status_before_2nd", 5); cycle(1'b0, ADDR_STATUS, 0);
            end else if (cnt == 205) begin
                exp_rd("ovr_status", 7); exp_irq("ovr_irq", 1'b1); cycle(1'b0, ADDR_STATUS, 0);
            end else if (cnt == 206) begin
                exp_irq("ovr_irq_at_ack", 1'b1); cycle(1'b1, ADDR_CTRL, 7);
            end else if (cnt == 207) begin
                exp_rd("ovr_status_after_ack", 4); exp_irq("ovr_irq_dropped", 1'b0);
                cycle(1'b0, ADDR_STATUS, 0);
            end else begin
                cycle(1'b0, ADDR_STATUS, 0);
            end
        end
        cnt = 1000;
        cycle(1'b1, ADDR_CTRL, 4);

        // COMPARE write in the match cycle suppresses the event
        cycle(1'b1, ADDR_COMPARE, 300);
        cycle(1'b1, ADDR_CTRL, 1);
        cnt = 299;
        while (cnt <= 311) begin
            if (cnt == 300) begin
                cycle(1'b1, ADDR_COMPARE, 310);
            end else if (cnt == 301) begin
                exp_rd("simul_cmp_status", 4); cycle(1'b0, ADDR_STATUS, 0);
            end else if (cnt == 302) begin
                exp_rd("simul_cmp_newval", 310); cycle(1'b0, ADDR_COMPARE, 0);
            end else if (cnt == 311) begin
                exp_rd("simul_cmp_fired", 9); cycle(1'b0, ADDR_STATUS, 0);
            end else begin
                cycle(1'b0, ADDR_STATUS, 0);
            end
        end
        cycle(1'b1, ADDR_CTRL, 4);

        // ACK in the match cycle keeps PENDING and does not flag OVERRUN
        cycle(1'b1, ADDR_COMPARE, 400);
        cycle(1'b1, ADDR_PERIOD, 2);
        cycle(1'b1, ADDR_CTRL, 3);
        cnt = 399;
        while (cnt <= 403) begin
            if (cnt == 402) begin
                cycle(1'b1, ADDR_CTRL, 7);
            end else if (cnt == 403) begin
                exp_rd("simul_ack_status", 5); cycle(1'b0, ADDR_STATUS, 0);
            end else begin
                cycle(1'b0, ADDR_STATUS, 0);
            end
        end
        cnt = 2000;
        cycle(1'b1, ADDR_CTRL, 4);

        // Reset one cycle before a match
        cycle(1'b1, ADDR_COMPARE, 500);
        cycle(1'b1, ADDR_CTRL, 1);
        cnt = 498;
        exp_rd("pre_reset_compare", 500); cycle(1'b0, ADDR_COMPARE, 0);
        we = 1'b0; addr = ADDR_STATUS; count_in = cnt;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_rdata", rdata, '0);
        chk("rst_mid_irq", {{(W-1){1'b0}}, irq}, '0);
        @(negedge clk);
        count_in = 500;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            exp_rd($sformatf("post_reset_status%0d", i), 0);
            exp_irq($sformatf("post_reset_irq%0d", i), 1'b0);
            cycle(1'b0, ADDR_STATUS, 0);
        end

        // Disable while PENDING
        cycle(1'b1, ADDR_COMPARE, 600);
        cycle(1'b1, ADDR_CTRL, 1);
        cnt = 600;
        cycle(1'b0, ADDR_STATUS, 0);
        cycle(1'b0, ADDR_STATUS, 0);
        exp_irq("dis_irq_before", 1'b1); cycle(1'b1, ADDR_CTRL, 0);
        exp_rd("dis_status", 1); exp_irq("dis_irq_after", 1'b0); cycle(1'b0, ADDR_STATUS, 0);
        cycle(1'b1, ADDR_STATUS, 32'hFFFF_FFFF);
        exp_rd("status_write_ignored", 1); cycle(1'b0, ADDR_STATUS, 0);

        repeat (3) @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_total = n_total + 1;
            $display("FAIL %s: got no sample expected a sample at edge %0d", e.name, e.cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cycle_timer.md
CYCLE_TIMER -- requirements
Module: cycle_timer

Interface
REQ-001 SHALL have parameter W, default 32: width of the count bus and of the COMPARE and PERIOD registers.
REQ-002 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port count_in, input, W: free-running cycle count value, unsigned; increments by 1 per clk and wraps.
REQ-005 SHALL have port we, input, 1: register write strobe, one cycle per write.
REQ-006 SHALL have port addr, input, 2: register select. 0=COMPARE, 1=PERIOD, 2=CTRL, 3=STATUS.
REQ-007 SHALL have port wdata, input, W: write data.
REQ-008 SHALL have port rdata, output, W: registered read data for addr.
REQ-009 SHALL have port irq, output, 1: registered interrupt request.

Function
REQ-010 CTRL bits SHALL be: bit0 EN, bit1 PERIODIC, bit2 ACK (write-1-to-clear pending; self-clearing, always reads 0). All other CTRL bits SHALL be ignored on write and SHALL read as 0.
REQ-011 STATUS SHALL be read-only: bit0 PENDING, bit1 OVERRUN, bits[3:2] state encoding, all other bits 0. Writes to STATUS SHALL be ignored.
REQ-012 rdata SHALL reflect the register value at addr one cycle after addr is presented (1-cycle read latency), independent of we.
REQ-013 The FSM SHALL have these states: IDLE=0, ARMED=1, FIRED=2.
- IDLE -> ARMED: on a write of EN=1.
- ARMED -> FIRED: on match (count_in == COMPARE) in a one-shot context, i.e. PERIODIC=0, or PERIODIC=1 with PERIOD=0.
- ARMED stays ARMED: on match with PERIODIC=1 and PERIOD!=0; COMPARE <= COMPARE+PERIOD mod 2^W.
- FIRED -> ARMED: on a write to COMPARE while EN=1.
- Any state -> IDLE: on a write of EN=0.
REQ-014 A match SHALL be detected only in ARMED and SHALL set PENDING the following cycle.
REQ-015 A match while PENDING=1 SHALL set OVERRUN (sticky); OVERRUN SHALL be cleared only by ACK or reset.
REQ-016 irq SHALL equal PENDING and EN registered, asserting one cycle after PENDING sets.
REQ-017 Match detection SHALL use equality only, so counter wrap from 2^W-1 to 0 SHALL need no special handling. The COMPARE reload addition SHALL wrap modulo 2^W.
REQ-018 A write to COMPARE in the same cycle as a match SHALL take priority: the new value loads, and no event, reload or PENDING update occurs.
REQ-019 ACK in the same cycle as a match SHALL leave PENDING=1 and OVERRUN=0.
REQ-020 A write of EN=0 SHALL not clear PENDING. irq SHALL deassert because EN=0.
REQ-021 PERIOD writes SHALL take effect at the next reload and SHALL not move the current COMPARE.

Reset
REQ-022 rst SHALL force state=IDLE and COMPARE, PERIOD, CTRL, PENDING, OVERRUN, rdata and irq all to 0, immediately and asynchronously.
REQ-023 rst asserted mid-operation SHALL discard any match in flight. After release the block SHALL stay IDLE until EN is written.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding, the address constants ADDR_COMPARE/ADDR_PERIOD/ADDR_CTRL/ADDR_STATUS, and the CTRL/STATUS bit indices.
REQ-025 One sub-module, timer_regfile, SHALL hold register storage and the read mux. The FSM and match logic SHALL stay in cycle_timer.

Verification
REQ-026 One-shot: COMPARE=100, CTRL=1, count_in 95..105 -> PENDING set the cycle after count_in=100, irq the cycle after that, state=FIRED, and no further events.
REQ-027 Periodic with wrap: COMPARE=0xFFFFFFF0, PERIOD=0x20, CTRL=3 -> events at count_in 0xFFFFFFF0 and 0x10, with COMPARE reading 0x30 after the second event.
REQ-028 Overrun: periodic PERIOD=4 with no ACK -> OVERRUN=1 after the second match. Then ACK=1 -> PENDING=0, OVERRUN=0, irq drops 1 cycle later.
REQ-029 Simultaneous events:
- COMPARE write at the match cycle -> no PENDING.
- ACK at a match cycle -> PENDING remains 1.
REQ-030 Reset mid-run: assert rst while ARMED one cycle before a match -> all outputs 0 immediately, no irq after release, STATUS reads 0.
REQ-031 Disable: EN=0 write while PENDING=1 -> irq=0 next cycle, PENDING still 1, state=IDLE.
